// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId, interrupt/exception merge, mfc0/mtc0/eret.
// Optional BadVAddr (register 8) is built when CP0_BADVADDR_EN is defined.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2020_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic        EXLClr,
    input  logic [31:0] PC,
    input  logic [4:0]  ExcCode,
    input  logic        if_bd,
    input  logic [5:0]  HWInt,
    input  logic [31:0] VAddr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc_q;
    logic [31:0] badvaddr;

    logic        int_hit;
    logic        exc_hit;
    logic [31:0] epc_next;

    assign int_hit  = (|(HWInt & im)) & ie & ~exl;
    assign exc_hit  = (ExcCode != 5'd0) & ~exl;
    assign IntReq   = ~reset & (int_hit | exc_hit);
    // A delay-slot instruction restarts at its branch, one word earlier.
    assign epc_next = word_align(if_bd ? (PC - 32'd4) : PC);
    assign EPC      = epc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc_q    <= 32'd0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl      <= 1'b1;
                exc_code <= int_hit ? 5'd0 : ExcCode;
                bd       <= if_bd;
                epc_q    <= epc_next;
            end else begin
                if (WE && A2 == REG_SR) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end
                if (WE && A2 == REG_EPC)
                    epc_q <= word_align(DIn);
                // eret overrides a same-cycle mtc0 to EXL.
                if (EXLClr)
                    exl <= 1'b0;
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            badvaddr <= 32'd0;
        else if (IntReq && !int_hit && (ExcCode == 5'd4 || ExcCode == 5'd5))
            badvaddr <= VAddr;
    end
`else
    logic unused_vaddr;
    assign badvaddr     = 32'd0;
    assign unused_vaddr = ^VAddr;
`endif

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_BADVADDR: DOut = badvaddr;
            REG_SR:       DOut = {16'd0, im, 8'd0, exl, ie};
            REG_CAUSE:    DOut = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            REG_EPC:      DOut = epc_q;
            REG_PRID:     DOut = PRID;
            default:      DOut = 32'd0;
        endcase
    end

endmodule
